// File: rtl/dense1_ctrl.sv
// -----------------------------------------------------------------------------
// dense1_ctrl
//
// Frame sequencer for the dense1 fully-connected stage. On an accepted start it
// reads N_IN signed 16-bit features from the flattened-feature buffer and
// streams them into dense1 as one framed burst. In parallel it collects the
// N_OUT framed sigmoid results into the result buffer. Completion, result
// length errors and idle timeouts are reported to the layer scheduler.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle request, honoured only in IDLE
//   busy, done          busy from the cycle after start through DONE; done pulse
//   err_len             sticky: result frame length differed from N_OUT
//   err_timeout         sticky: TIMEOUT cycles passed without a result beat
//   mem_rd_en/mem_addr  feature buffer read port
//   mem_rdata           feature data, valid one cycle after mem_rd_en
//   ena, frame_start_in, frame_end_in, dense_input
//                       framed element stream into dense1
//   valid, frame_start_out, frame_end_out, dense_sigmoid_out
//                       framed result stream from dense1
//   out_wr_en/out_addr/out_data
//                       result buffer write port
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | issuing N_IN feature reads, addr 0..N_IN-1
// DRAIN  | reads done, waiting for the last element to leave the feed pipe
// WAIT   | element stream complete, waiting for the result frame to close
// DONE   | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module dense1_ctrl #(
  parameter int N_IN    = 64,
  parameter int N_OUT   = 10,
  parameter int TIMEOUT = 4096,
  parameter int AW_IN   = $clog2(N_IN),
  parameter int AW_OUT  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              err_timeout,
  output logic              mem_rd_en,
  output logic [AW_IN-1:0]  mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              ena,
  output logic              frame_start_in,
  output logic              frame_end_in,
  output logic [15:0]       dense_input,
  input  logic              valid,
  input  logic              frame_start_out,
  input  logic              frame_end_out,
  input  logic [15:0]       dense_sigmoid_out,
  output logic              out_wr_en,
  output logic [AW_OUT-1:0] out_addr,
  output logic [15:0]       out_data
);

  // Result count can run past N_OUT on long frames, so it needs one value more
  // than the address space.
  localparam int CW = $clog2(N_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             start_acc;
  logic             active;
  logic             last_addr;
  logic             to_fire;

  logic             rd_d1;
  logic [AW_IN-1:0] addr_d1;
  logic             fed_last;

  logic [TW-1:0]    tcnt;

  logic             armed;
  logic             closed;
  logic [CW-1:0]    count;

  assign start_acc = (state == S_IDLE) && start;
  assign active    = (state == S_FETCH) || (state == S_DRAIN) || (state == S_WAIT);
  assign last_addr = (mem_addr == AW_IN'(N_IN - 1));

  // Fires on the cycle whose idle increment would bring the counter to TIMEOUT,
  // so DONE lands exactly TIMEOUT cycles after the last clear.
  assign to_fire = active && !valid && (tcnt == TW'(TIMEOUT - 1));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (last_addr) state_nxt = S_DRAIN;
      // fed_last trails the final ena by one cycle; a frame that already closed
      // skips WAIT entirely.
      S_DRAIN: if (fed_last) state_nxt = closed ? S_DONE : S_WAIT;
      S_WAIT:  if (closed) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (to_fire) state_nxt = S_DONE;
  end

  // ---------------------------------------------------------------------------
  // Feature read address generator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else if (start_acc) begin
      mem_rd_en <= 1'b1;
      mem_addr  <= '0;
    end else if (state == S_FETCH) begin
      if (last_addr || to_fire) begin
        mem_rd_en <= 1'b0;
        mem_addr  <= '0;
      end else begin
        mem_addr  <= mem_addr + AW_IN'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Feed pipeline: read strobe -> data returns next cycle -> registered out.
  // A timeout flushes everything in flight so ena drops at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1          <= 1'b0;
      addr_d1        <= '0;
      ena            <= 1'b0;
      frame_start_in <= 1'b0;
      frame_end_in   <= 1'b0;
      dense_input    <= '0;
      fed_last       <= 1'b0;
    end else begin
      rd_d1    <= mem_rd_en && !to_fire;
      addr_d1  <= mem_addr;
      fed_last <= ena && frame_end_in && !to_fire;
      if (rd_d1 && !to_fire) begin
        ena            <= 1'b1;
        dense_input    <= mem_rdata;
        frame_start_in <= (addr_d1 == '0);
        frame_end_in   <= (addr_d1 == AW_IN'(N_IN - 1));
      end else begin
        ena            <= 1'b0;
        frame_start_in <= 1'b0;
        frame_end_in   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timeout: cleared by start and by every result beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else if (start_acc) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else if (active) begin
      tcnt <= valid ? '0 : tcnt + TW'(1);
      if (to_fire) err_timeout <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result collector. Runs throughout FETCH/DRAIN/WAIT since dense1 may answer
  // before the input burst has finished. Once the frame closes, later beats
  // are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      closed    <= 1'b0;
      count     <= '0;
      err_len   <= 1'b0;
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_wr_en <= 1'b0;
      if (start_acc) begin
        armed   <= 1'b0;
        closed  <= 1'b0;
        count   <= '0;
        err_len <= 1'b0;
      end else if (active && valid && !closed) begin
        if (frame_start_out) begin
          // A restart while armed is a length fault; a start+end beat is a
          // one-element frame and therefore always too short.
          if (armed || frame_end_out) err_len <= 1'b1;
          armed     <= 1'b1;
          count     <= CW'(1);
          out_wr_en <= 1'b1;
          out_addr  <= '0;
          out_data  <= dense_sigmoid_out;
          if (frame_end_out) closed <= 1'b1;
        end else if (armed) begin
          if (count < CW'(N_OUT)) begin
            out_wr_en <= 1'b1;
            out_addr  <= count[AW_OUT-1:0];
            out_data  <= dense_sigmoid_out;
            count     <= count + CW'(1);
            if (frame_end_out && (count != CW'(N_OUT - 1))) err_len <= 1'b1;
          end else begin
            err_len <= 1'b1;
          end
          if (frame_end_out) closed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense1_ctrl.sv
module tb_dense1_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, err_len, err_timeout;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        ena, frame_start_in, frame_end_in;
  logic [15:0] dense_input;
  logic        valid, frame_start_out, frame_end_out;
  logic [15:0] dense_sigmoid_out;
  logic        out_wr_en;
  logic [3:0]  out_addr;
  logic [15:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  dense1_ctrl #(.N_IN(64), .N_OUT(10), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ena(ena), .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
    .dense_input(dense_input),
    .valid(valid), .frame_start_out(frame_start_out), .frame_end_out(frame_end_out),
    .dense_sigmoid_out(dense_sigmoid_out),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Feature buffer: synchronous read, value = addr - 32.
  always @(posedge clk) mem_rdata <= mem_rd_en ? 16'(int'(mem_addr) - 32) : 16'h0;

  // Monitor: cumulative logs, sampled at the falling edge.
  int          ena_cnt = 0, ena_bad = 0, ena_last = 0;
  int          fs_cyc = 0, fe_cyc = 0;
  logic [15:0] fs_val = 0, fe_val = 0, exp_elem = 0;
  int          rd_cnt = 0, rd_bad = 0;
  logic [5:0]  exp_addr = 0;
  logic        prev_rd = 0;
  int          wr_cnt = 0;
  int          wr_addr_log[64];
  logic [15:0] wr_data_log[64];
  int          wr_cyc_log[64];
  int          done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (ena) begin
      if (frame_start_in) begin
        exp_elem = 16'hffe0;
        fs_cyc   = cyc;
        fs_val   = dense_input;
      end else begin
        exp_elem = exp_elem + 16'd1;
      end
      if (dense_input !== exp_elem) ena_bad++;
      if (frame_end_in) begin
        fe_cyc = cyc;
        fe_val = dense_input;
      end
      ena_cnt++;
      ena_last = cyc;
    end
    if (mem_rd_en) begin
      exp_addr = prev_rd ? exp_addr + 6'd1 : 6'd0;
      if (mem_addr !== exp_addr) rd_bad++;
      rd_cnt++;
    end
    prev_rd = mem_rd_en;
    if (out_wr_en) begin
      wr_addr_log[wr_cnt % 64] = int'(out_addr);
      wr_data_log[wr_cnt % 64] = out_data;
      wr_cyc_log[wr_cnt % 64]  = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Per-cycle snapshots of the current frame, index = cycles since start.
  logic       snap_busy[256];
  logic       snap_rd[256];
  logic       snap_el[256];
  logic       snap_et[256];
  logic [5:0] snap_addr[256];

  task automatic begin_frame(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
  endtask

  // dense1 model: nb beats starting at rel cycle off, frame_end on beat end_idx,
  // plus an optional unarmed beat at rel cycle stray.
  task automatic drive(input int off, input int nb, input int end_idx,
                       input int stray, input int last_rel, input bit hold);
    for (int r = 1; r <= last_rel; r++) begin
      @(negedge clk);
      snap_busy[r] = busy;
      snap_rd[r]   = mem_rd_en;
      snap_addr[r] = mem_addr;
      snap_el[r]   = err_len;
      snap_et[r]   = err_timeout;
      start           = hold;
      valid           = ((r >= off) && (r < off + nb)) || (r == stray);
      frame_start_out = (r == off);
      frame_end_out   = (r >= off) && (r < off + nb) && ((r - off) == end_idx);
      dense_sigmoid_out = 16'(100 + r - off);
    end
    valid = 1'b0;
    frame_start_out = 1'b0;
    frame_end_out = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, done, err_len, err_timeout, mem_rd_en, mem_addr, ena, frame_start_in, frame_end_in, dense_input, out_wr_en, out_addr, out_data} !== 51'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", {busy, done, err_len, err_timeout, mem_rd_en, mem_addr, ena, frame_start_in, frame_end_in, dense_input, out_wr_en, out_addr, out_data}); end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    int t, e0, eb0, r0, rb0, w0, d0;
    e0 = ena_cnt; eb0 = ena_bad; r0 = rd_cnt; rb0 = rd_bad; w0 = wr_cnt; d0 = done_cnt;
    begin_frame(t);
    drive(86, 10, 9, -1, 110, 1'b0);
    vectors++; if (snap_busy[1] !== 1'b1) begin miscompares++; $display("FAIL nom_busy_t1: got %b want 1", snap_busy[1]); end
    vectors++; if (snap_rd[1] !== 1'b1 || snap_addr[1] !== 6'd0) begin miscompares++; $display("FAIL nom_rd_t1: got en=%b addr=%0d want en=1 addr=0", snap_rd[1], snap_addr[1]); end
    vectors++; if (rd_cnt - r0 != 64) begin miscompares++; $display("FAIL nom_rd_cnt: got %0d want 64", rd_cnt - r0); end
    vectors++; if (rd_bad - rb0 != 0) begin miscompares++; $display("FAIL nom_rd_addr_seq: got %0d bad want 0", rd_bad - rb0); end
    vectors++; if (ena_cnt - e0 != 64) begin miscompares++; $display("FAIL nom_ena_cnt: got %0d want 64", ena_cnt - e0); end
    vectors++; if (ena_bad - eb0 != 0) begin miscompares++; $display("FAIL nom_elem_data: got %0d bad want 0", ena_bad - eb0); end
    vectors++; if (fs_cyc != t + 3 || fs_val !== 16'hffe0) begin miscompares++; $display("FAIL nom_frame_start_in: got cyc+%0d val %h want cyc+3 val ffe0", fs_cyc - t, fs_val); end
    vectors++; if (fe_cyc != t + 66 || fe_val !== 16'd31) begin miscompares++; $display("FAIL nom_frame_end_in: got cyc+%0d val %0d want cyc+66 val 31", fe_cyc - t, fe_val); end
    vectors++; if (ena_last != t + 66) begin miscompares++; $display("FAIL nom_ena_last: got +%0d want +66", ena_last - t); end
    vectors++; if (wr_cnt - w0 != 10) begin miscompares++; $display("FAIL nom_wr_cnt: got %0d want 10", wr_cnt - w0); end
    for (int i = 0; i < 10; i++) begin
      vectors++; if (wr_addr_log[(w0 + i) % 64] != i || wr_data_log[(w0 + i) % 64] !== 16'(100 + i) || wr_cyc_log[(w0 + i) % 64] != t + 87 + i) begin miscompares++; $display("FAIL nom_write%0d: got addr %0d data %0d cyc+%0d want addr %0d data %0d cyc+%0d", i, wr_addr_log[(w0 + i) % 64], wr_data_log[(w0 + i) % 64], wr_cyc_log[(w0 + i) % 64] - t, i, 100 + i, 87 + i); end
    end
    vectors++; if (done_cnt - d0 != 1 || done_cyc != t + 97) begin miscompares++; $display("FAIL nom_done: got %0d pulses at +%0d want 1 at +97", done_cnt - d0, done_cyc - t); end
    vectors++; if (snap_busy[97] !== 1'b1 || snap_busy[98] !== 1'b0) begin miscompares++; $display("FAIL nom_busy_end: got %b%b want 10", snap_busy[97], snap_busy[98]); end
    vectors++; if (err_len !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("FAIL nom_errs: got len=%b to=%b want 0 0", err_len, err_timeout); end
  endtask

  task automatic test_short_frame();
    int t, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    begin_frame(t);
    drive(70, 8, 7, -1, 90, 1'b0);
    vectors++; if (wr_cnt - w0 != 8) begin miscompares++; $display("FAIL short_wr_cnt: got %0d want 8", wr_cnt - w0); end
    vectors++; if (wr_addr_log[(w0 + 7) % 64] != 7) begin miscompares++; $display("FAIL short_last_addr: got %0d want 7", wr_addr_log[(w0 + 7) % 64]); end
    vectors++; if (err_len !== 1'b1) begin miscompares++; $display("FAIL short_err_len: got %b want 1", err_len); end
    vectors++; if (done_cnt - d0 != 1 || done_cyc != t + 79) begin miscompares++; $display("FAIL short_done: got %0d at +%0d want 1 at +79", done_cnt - d0, done_cyc - t); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL short_err_timeout: got %b want 0", err_timeout); end
  endtask

  task automatic test_long_frame();
    int t, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    begin_frame(t);
    drive(70, 12, 11, -1, 95, 1'b0);
    vectors++; if (snap_el[1] !== 1'b0) begin miscompares++; $display("FAIL long_err_cleared: got %b want 0", snap_el[1]); end
    vectors++; if (snap_el[80] !== 1'b0 || snap_el[81] !== 1'b1) begin miscompares++; $display("FAIL long_err_edge: got %b%b want 01", snap_el[80], snap_el[81]); end
    vectors++; if (wr_cnt - w0 != 10) begin miscompares++; $display("FAIL long_wr_cnt: got %0d want 10", wr_cnt - w0); end
    for (int i = 0; i < 10; i++) begin
      vectors++; if (wr_addr_log[(w0 + i) % 64] != i) begin miscompares++; $display("FAIL long_addr%0d: got %0d want %0d", i, wr_addr_log[(w0 + i) % 64], i); end
    end
    vectors++; if (err_len !== 1'b1) begin miscompares++; $display("FAIL long_err_len: got %b want 1", err_len); end
    vectors++; if (done_cnt - d0 != 1 || done_cyc != t + 83) begin miscompares++; $display("FAIL long_done: got %0d at +%0d want 1 at +83", done_cnt - d0, done_cyc - t); end
  endtask

  task automatic test_clean_after_error();
    int t, w0;
    w0 = wr_cnt;
    begin_frame(t);
    drive(70, 10, 9, -1, 90, 1'b0);
    vectors++; if (snap_el[1] !== 1'b0) begin miscompares++; $display("FAIL clean_err_cleared: got %b want 0", snap_el[1]); end
    vectors++; if (err_len !== 1'b0) begin miscompares++; $display("FAIL clean_err_len: got %b want 0", err_len); end
    vectors++; if (wr_cnt - w0 != 10) begin miscompares++; $display("FAIL clean_wr_cnt: got %0d want 10", wr_cnt - w0); end
    vectors++; if (done_cyc != t + 81) begin miscompares++; $display("FAIL clean_done: got +%0d want +81", done_cyc - t); end
  endtask

  task automatic test_timeout();
    int t, w0, d0, e0;
    w0 = wr_cnt; d0 = done_cnt; e0 = ena_cnt;
    begin_frame(t);
    drive(1000, 0, 0, -1, 110, 1'b0);
    vectors++; if (done_cnt - d0 != 1 || done_cyc != t + 101) begin miscompares++; $display("FAIL to_done: got %0d at +%0d want 1 at +101", done_cnt - d0, done_cyc - t); end
    vectors++; if (snap_et[100] !== 1'b0 || snap_et[101] !== 1'b1) begin miscompares++; $display("FAIL to_err_edge: got %b%b want 01", snap_et[100], snap_et[101]); end
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky: got %b want 1", err_timeout); end
    vectors++; if (wr_cnt - w0 != 0) begin miscompares++; $display("FAIL to_writes: got %0d want 0", wr_cnt - w0); end
    vectors++; if (err_len !== 1'b0) begin miscompares++; $display("FAIL to_err_len: got %b want 0", err_len); end
    vectors++; if (ena_cnt - e0 != 64) begin miscompares++; $display("FAIL to_ena_cnt: got %0d want 64", ena_cnt - e0); end
  endtask

  task automatic test_early_results();
    int t, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    begin_frame(t);
    drive(20, 10, 9, 10, 80, 1'b0);
    vectors++; if (snap_et[1] !== 1'b0) begin miscompares++; $display("FAIL early_to_cleared: got %b want 0", snap_et[1]); end
    vectors++; if (wr_cnt - w0 != 10) begin miscompares++; $display("FAIL early_wr_cnt: got %0d want 10", wr_cnt - w0); end
    vectors++; if (wr_addr_log[w0 % 64] != 0 || wr_cyc_log[w0 % 64] != t + 21) begin miscompares++; $display("FAIL early_first_write: got addr %0d at +%0d want addr 0 at +21", wr_addr_log[w0 % 64], wr_cyc_log[w0 % 64] - t); end
    vectors++; if (done_cnt - d0 != 1 || done_cyc != t + 68) begin miscompares++; $display("FAIL early_done: got %0d at +%0d want 1 at +68", done_cnt - d0, done_cyc - t); end
    vectors++; if (err_len !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("FAIL early_errs: got len=%b to=%b want 0 0", err_len, err_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    begin_frame(t);
    drive(1000, 0, 0, -1, 31, 1'b0);
    vectors++; if (snap_rd[31] !== 1'b1 || snap_addr[31] !== 6'd30) begin miscompares++; $display("FAIL rstmid_pos: got en=%b addr=%0d want en=1 addr=30", snap_rd[31], snap_addr[31]); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({busy, done, err_len, err_timeout, mem_rd_en, mem_addr, ena, frame_start_in, frame_end_in, dense_input, out_wr_en, out_addr, out_data} !== 51'd0) begin miscompares++; $display("FAIL rstmid_outputs: got %h want 0", {busy, done, err_len, err_timeout, mem_rd_en, mem_addr, ena, frame_start_in, frame_end_in, dense_input, out_wr_en, out_addr, out_data}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if ({busy, mem_rd_en, ena, out_wr_en} !== 4'b0) begin miscompares++; $display("FAIL rstmid_residual: got %b want 0000", {busy, mem_rd_en, ena, out_wr_en}); end
    test_nominal();
  endtask

  task automatic test_start_held();
    int t, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    begin_frame(t);
    drive(70, 10, 9, -1, 82, 1'b1);
    vectors++; if (done_cnt - d0 != 1 || done_cyc != t + 81) begin miscompares++; $display("FAIL held_first_done: got %0d at +%0d want 1 at +81", done_cnt - d0, done_cyc - t); end
    vectors++; if (snap_busy[82] !== 1'b0 || snap_rd[82] !== 1'b0) begin miscompares++; $display("FAIL held_idle_gap: got busy=%b rd=%b want 0 0", snap_busy[82], snap_rd[82]); end
    drive(70, 10, 9, -1, 90, 1'b0);
    vectors++; if (snap_busy[1] !== 1'b1 || snap_rd[1] !== 1'b1 || snap_addr[1] !== 6'd0) begin miscompares++; $display("FAIL held_second_start: got busy=%b rd=%b addr=%0d want 1 1 0", snap_busy[1], snap_rd[1], snap_addr[1]); end
    vectors++; if (done_cnt - d0 != 2 || done_cyc != t + 82 + 81) begin miscompares++; $display("FAIL held_second_done: got %0d at +%0d want 2 at +163", done_cnt - d0, done_cyc - t); end
    vectors++; if (wr_cnt - w0 != 20) begin miscompares++; $display("FAIL held_wr_cnt: got %0d want 20", wr_cnt - w0); end
    vectors++; if (err_len !== 1'b0) begin miscompares++; $display("FAIL held_err_len: got %b want 0", err_len); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    frame_start_out = 1'b0;
    frame_end_out = 1'b0;
    dense_sigmoid_out = 16'h0;
    test_reset();
    test_nominal();
    test_short_frame();
    test_long_frame();
    test_clean_after_error();
    test_timeout();
    test_early_results();
    test_reset_mid_frame();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
